// File: rtl/enum_var_pkg.sv
// Shared types for the enum_var_tracker: the t_var variable encoding,
// the per-channel frame-protocol state, and the data-variable classifier.
package enum_var_pkg;

    typedef enum integer {
        var_presence = 0,
        var_identif  = 1,
        var_1        = 2,
        var_2        = 3,
        var_3        = 4,
        var_4        = 5,
        var_5        = 6,
        var_rst      = 7,
        var_whatever = 8
    } t_var;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRES  = 3'd1,
        IDENT = 3'd2,
        DATA  = 3'd3,
        ERR   = 3'd4
    } t_chan_state;

    function automatic logic is_dvar(input t_var v);
        return (v == var_1) || (v == var_2) || (v == var_3) ||
               (v == var_4) || (v == var_5);
    endfunction

endpackage

// File: rtl/enum_var_chan.sv
// One tracker channel: frame-protocol FSM, saturating data counter and
// registered outputs. Optional ERR-entry counter under ENUM_VAR_ERR_CNT_EN.
//
// state | meaning
// IDLE  | waiting for the presence variable that opens a frame
// PRES  | presence seen, waiting for identification
// IDENT | identification seen, waiting for the first data variable
// DATA  | counting data variables; presence starts a new frame
// ERR   | protocol violation, sticky until var_rst
module enum_var_chan
    import enum_var_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  t_var              var_i,
    output t_var              var_o,
    output logic              is_var_rst_o,
    output logic              rst_pulse_o,
    output t_chan_state       state_o,
    output logic [CNT_W-1:0]  data_cnt_o,
`ifdef ENUM_VAR_ERR_CNT_EN
    output logic [CNT_W-1:0]  err_cnt_o,
`endif
    output logic              err_o
);

    t_chan_state      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    t_var             var_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            var_q   <= var_presence;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            if (valid_i) begin
                var_q <= var_i;
            end
        end
    end

    // var_rst outranks everything; var_whatever is a no-op for the FSM.
    // Out-of-range encodings fall through to the ERR branches.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (valid_i) begin
            if (var_i == var_rst) begin
                state_d = IDLE;
                cnt_d   = '0;
                pulse_d = 1'b1;
            end else if (var_i != var_whatever) begin
                case (state_q)
                    IDLE: begin
                        if (var_i == var_presence) state_d = PRES;
                        else                       state_d = ERR;
                    end
                    PRES: begin
                        if (var_i == var_identif)       state_d = IDENT;
                        else if (var_i != var_presence) state_d = ERR;
                    end
                    IDENT: begin
                        if (is_dvar(var_i)) begin
                            state_d = DATA;
                            cnt_d   = CNT_W'(1);
                        end else begin
                            state_d = ERR;
                        end
                    end
                    DATA: begin
                        if (is_dvar(var_i)) begin
                            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                        end else if (var_i == var_presence) begin
                            state_d = PRES;
                            cnt_d   = '0;
                        end else begin
                            state_d = ERR;
                        end
                    end
                    ERR:     state_d = ERR;
                    default: state_d = ERR;
                endcase
            end
        end
    end

`ifdef ENUM_VAR_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if ((state_d == ERR) && (state_q != ERR) && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
    end

    assign err_cnt_o = err_cnt_q;
`endif

    assign var_o        = var_q;
    assign is_var_rst_o = (var_q == var_rst);
    assign rst_pulse_o  = pulse_q;
    assign state_o      = state_q;
    assign data_cnt_o   = cnt_q;
    assign err_o        = (state_q == ERR);

endmodule

// File: rtl/enum_var_tracker.sv
// NCH independent frame-protocol trackers for t_var streams.
// Define ENUM_VAR_ERR_CNT_EN to add the per-channel err_cnt_o output.
module enum_var_tracker
    import enum_var_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NCH-1:0]             valid_i,
    input  t_var                       var_i [NCH],
    output t_var                       var_o [NCH],
    output logic [NCH-1:0]             is_var_rst_o,
    output logic [NCH-1:0]             rst_pulse_o,
    output t_chan_state                state_o [NCH],
    output logic [NCH-1:0][CNT_W-1:0]  data_cnt_o,
`ifdef ENUM_VAR_ERR_CNT_EN
    output logic [NCH-1:0][CNT_W-1:0]  err_cnt_o,
`endif
    output logic [NCH-1:0]             err_o
);

    for (genvar ch = 0; ch < NCH; ch++) begin : g_chan
        enum_var_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .valid_i      (valid_i[ch]),
            .var_i        (var_i[ch]),
            .var_o        (var_o[ch]),
            .is_var_rst_o (is_var_rst_o[ch]),
            .rst_pulse_o  (rst_pulse_o[ch]),
            .state_o      (state_o[ch]),
            .data_cnt_o   (data_cnt_o[ch]),
`ifdef ENUM_VAR_ERR_CNT_EN
            .err_cnt_o    (err_cnt_o[ch]),
`endif
            .err_o        (err_o[ch])
        );
    end

endmodule

// File: doc/enum_var_tracker.md
# enum_var_tracker

Multi-channel, clocked successor to the combinational `t_var` decoder. It accepts `t_var`-typed enum values on NCH independent valid-qualified channels and runs a per-channel frame-protocol FSM: presence, then identification, then data. Per channel it registers the last accepted value, reset detection, a saturating data-variable count and an error state. It sits between the variable-producing front end and the frame bookkeeping logic.

## Interface
Parameters:
- `NCH`, 4: number of independent channels, 1..16.
- `CNT_W`, 8: width of each per-channel data counter.

Ports:
- `clk`  input  1  single clock; all state on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `valid_i`  input  NCH  per-channel input qualifier.
- `var_i`  input  `t_var` [NCH]  per-channel enum value; sampled only when `valid_i[ch]`.
- `var_o`  output  `t_var` [NCH]  last accepted value per channel.
- `is_var_rst_o`  output  NCH  level: `var_o[ch] == var_rst`.
- `rst_pulse_o`  output  NCH  one-cycle pulse per accepted `var_rst`.
- `state_o`  output  `t_chan_state` [NCH]  current FSM state.
- `data_cnt_o`  output  CNT_W×NCH  data variables accepted in the current frame.
- `err_o`  output  NCH  high while the channel is in ERR.

## Operation
- **Channels:** fully independent; no arbitration; all may accept in the same cycle.
- **Accepting a value:** on `valid_i[ch]`, `var_o[ch]` takes `var_i[ch]` whatever the FSM does.
- **No valid:** with `valid_i[ch]` low, all channel state holds and `rst_pulse_o[ch]` is 0.
- **Data variables:** `var_1`..`var_5`, collectively DVAR.
- **FSM states:** IDLE, PRES, IDENT, DATA, ERR.
- **`var_rst`, any state:** go to IDLE; clear the counter; pulse `rst_pulse_o`. This has priority over every other rule.
- **`var_whatever`, any state:** no transition, no count change. Only `var_o` updates.
- **IDLE:** `var_presence` → PRES. Anything else → ERR.
- **PRES:** `var_identif` → IDENT. `var_presence` → stay. Anything else → ERR.
- **IDENT:** DVAR → DATA, counter = 1. Anything else → ERR.
- **DATA:**
  - DVAR → stay, counter +1, saturating at 2^CNT_W−1 with no wrap.
  - `var_presence` → PRES, counter cleared (new frame).
  - Anything else → ERR.
- **ERR:** sticky. Only `var_rst` leaves it. The counter is frozen while in ERR.
- **Out-of-range values:** an integer `var_i` that is not a legal enumerator is treated as illegal and sends the channel to ERR (from IDLE as well).
- **Reset values:**
  - `var_o` = `var_presence`
  - `state_o` = IDLE
  - `data_cnt_o` = 0
  - `is_var_rst_o`, `rst_pulse_o`, `err_o` = 0

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Latency is 1 cycle: a value accepted on edge N is visible on every output after edge N.
- `rst_pulse_o` is high for exactly one cycle per accepted `var_rst`. Back-to-back `var_rst` keeps it high on consecutive cycles.
- Throughput is one value per channel per cycle.
- `rst_n` asserted mid-frame returns all channels to reset values immediately, independent of `clk`. Deassertion is synchronised by the integrating design.

## Configuration
- **Macro:** `ENUM_VAR_ERR_CNT_EN`.
- **When defined:** adds output `err_cnt_o` (CNT_W×NCH), the per-channel count of transitions into ERR.
  - Saturating.
  - Cleared only by `rst_n`, not by `var_rst`.
  - Increments in the same cycle `err_o` rises.
- **When undefined:** the port and its logic are absent; all other behaviour is identical.

## Structure
- **Package `enum_var_pkg`:**
  - `t_var`: `integer`-based, values `var_presence`..`var_whatever` in order 0..8.
  - `t_chan_state` enum.
  - Helper function `is_dvar(t_var)`.
- **Sub-module `enum_var_chan`:** one channel (FSM, counter, output registers).
- **Top-level `enum_var_tracker`:** a generate loop over NCH instances.

## Test plan
- **Reset values:** reset, then release with no valid → `var_o` = `var_presence`, `state_o` = IDLE, counts 0 on every channel.
- **Normal frame, NCH=4:** ch0 fed `var_presence`, `var_identif`, `var_1`, `var_2`, `var_5` → state DATA, `data_cnt_o[0]`=3, other channels untouched.
- **Reset mid-frame:** `var_rst` on ch1 while in DATA with cnt=2 → next cycle IDLE, cnt 0, `rst_pulse_o[1]`=1 for one cycle, `is_var_rst_o[1]` stays 1 until the next accepted value.
- **ERR entry and exit:** `var_3` on ch2 in IDLE → ERR, `err_o[2]`=1. A following `var_presence` keeps it in ERR. `var_rst` → IDLE. With `ENUM_VAR_ERR_CNT_EN` defined, `err_cnt_o[2]`=1.
- **Saturation:** CNT_W=2, a frame with 6 DVARs → `data_cnt_o`=3. `var_whatever` interleaved → no count or state change.
- **Concurrency and async reset:** all 4 channels valid together with distinct legal sequences → independent correct results. `rst_n` low mid-clock → outputs reset without waiting for an edge.
